// File: rtl/alu32_pkg.sv
// Shared types, widths and constants for the 32-bit restoring divider,
// plus the prefix-adder cells used by the trial subtractor.
package alu32_pkg;

  localparam int unsigned WIDTH = 32;

  localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;
  localparam logic [31:0] SIGNED_MIN    = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIXUP,
    ST_DONE
  } state_t;

  // Grey cell: group generate only, used once the span already reaches bit 0
  function automatic logic grey_box(input logic g_hi, input logic p_hi, input logic g_lo);
    return g_hi | (p_hi & g_lo);
  endfunction

  // Black cell: combined {generate, propagate} of two adjacent spans
  function automatic logic [1:0] black_box(input logic g_hi, input logic p_hi,
                                           input logic g_lo, input logic p_lo);
    return {g_hi | (p_hi & g_lo), p_hi & p_lo};
  endfunction

endpackage

// File: rtl/div_sub_stage.sv
// Combinational N-bit a - b as a Kogge-Stone prefix adder on a + ~b + 1.
// borrow=1 means a < b (unsigned).
module div_sub_stage #(
  parameter int unsigned N = alu32_pkg::WIDTH + 1
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);
  import alu32_pkg::*;

  localparam int unsigned LEVELS = $clog2(N);

  logic [N-1:0] w_bn;
  logic [N-1:0] w_g0;
  logic [N-1:0] w_p0;
  logic [N-1:0] w_g [LEVELS+1];
  logic [N-1:0] w_p [LEVELS+1];
  logic [N-1:0] w_carry;

  assign w_bn = ~b;
  assign w_g0 = a & w_bn;
  assign w_p0 = a ^ w_bn;

  // Carry-in of 1 folded into bit 0's generate
  assign w_g[0] = {w_g0[N-1:1], w_g0[0] | w_p0[0]};
  assign w_p[0] = w_p0;

  for (genvar lvl = 0; lvl < LEVELS; lvl++) begin : g_level
    localparam int unsigned D = 1 << lvl;
    for (genvar i = 0; i < N; i++) begin : g_bit
      if (i < D) begin : g_pass
        assign w_g[lvl+1][i] = w_g[lvl][i];
        assign w_p[lvl+1][i] = w_p[lvl][i];
      end else if (i < 2 * D) begin : g_grey
        assign w_g[lvl+1][i] = grey_box(w_g[lvl][i], w_p[lvl][i], w_g[lvl][i-D]);
        assign w_p[lvl+1][i] = w_p[lvl][i];
      end else begin : g_black
        assign {w_g[lvl+1][i], w_p[lvl+1][i]} =
          black_box(w_g[lvl][i], w_p[lvl][i], w_g[lvl][i-D], w_p[lvl][i-D]);
      end
    end
  end

  assign w_carry = w_g[LEVELS];
  assign diff    = w_p0 ^ {w_carry[N-2:0], 1'b1};
  assign borrow  = ~w_carry[N-1];

endmodule

// File: rtl/alu32_divider.sv
// Multi-cycle signed/unsigned restoring divider: one quotient bit per cycle
// through a single shared trial subtractor, valid/ready on both sides.
module alu32_divider #(
  parameter int unsigned WIDTH = alu32_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  import alu32_pkg::*;

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_div0;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH:0]   r_rem;
  logic [CNT_W-1:0] r_cnt;
  logic             r_q_neg;
  logic             r_r_neg;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_borrow;
  logic [WIDTH-1:0] w_dvd_abs;
  logic [WIDTH-1:0] w_dvs_abs;
  logic             w_ovf;
  logic             w_unused;

  // r_dvd shifts dividend bits out of the top and quotient bits in at the bottom
  assign w_shift  = {r_rem[WIDTH-1:0], r_dvd[WIDTH-1]};
  assign w_unused = r_rem[WIDTH];

  assign w_dvd_abs = (is_signed && dividend[WIDTH-1]) ? (~dividend + WIDTH'(1)) : dividend;
  assign w_dvs_abs = (is_signed && divisor[WIDTH-1])  ? (~divisor + WIDTH'(1))  : divisor;
  assign w_ovf     = is_signed && (dividend == WIDTH'(SIGNED_MIN)) && (divisor == '1);

  div_sub_stage #(.N(WIDTH + 1)) u_sub (
    .a      (w_shift),
    .b      ({1'b0, r_dvs}),
    .diff   (w_diff),
    .borrow (w_borrow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_div0      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_in_ready <= 1'b0;
            if (divisor == '0) begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
              r_quotient  <= WIDTH'(DIV0_QUOTIENT);
              r_remainder <= dividend;
              r_div0      <= 1'b1;
            end else if (w_ovf) begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
              r_quotient  <= WIDTH'(SIGNED_MIN);
              r_remainder <= '0;
              r_div0      <= 1'b0;
            end else begin
              r_state <= ST_CALC;
              r_dvd   <= w_dvd_abs;
              r_dvs   <= w_dvs_abs;
              r_q_neg <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              r_r_neg <= is_signed & dividend[WIDTH-1];
              r_rem   <= '0;
              r_cnt   <= '0;
              r_div0  <= 1'b0;
            end
          end
        end
        ST_CALC: begin
          r_rem <= w_borrow ? w_shift : w_diff;
          r_dvd <= {r_dvd[WIDTH-2:0], ~w_borrow};
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_state <= ST_FIXUP;
          end
        end
        ST_FIXUP: begin
          r_quotient  <= r_q_neg ? (~r_dvd + WIDTH'(1)) : r_dvd;
          r_remainder <= r_r_neg ? (~r_rem[WIDTH-1:0] + WIDTH'(1)) : r_rem[WIDTH-1:0];
          r_out_valid <= 1'b1;
          r_state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div0;

endmodule

// File: tb/tb_alu32_divider.sv
// Directed bench for alu32_divider: hand-computed vectors, latency,
// back-pressure hold and reset abort.
module tb_alu32_divider;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        is_signed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_cmp;
  int n_fail;

  alu32_divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .is_signed   (is_signed),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one operation, then wait (bounded) for out_valid; lat counts the accept edge as 1
  task automatic do_op(input logic [31:0] dvd, input logic [31:0] dvs, input logic sg,
                       input bit toggle, output int lat);
    @(negedge clk);
    chk("ready_before_accept", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    dividend  = dvd;
    divisor   = dvs;
    is_signed = sg;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      if (toggle) begin
        in_valid = ~in_valid;
        dividend = 32'd5;
        divisor  = 32'd5;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    chk("no_ready_in_done", 32'(in_ready), 32'd0);
  endtask

  // Handshake the result and confirm the return to IDLE
  task automatic release_op(input string tag);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_ready_rise"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    int seen;
    n_cmp     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    dividend  = '0;
    divisor   = '0;
    is_signed = 1'b0;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  32'(in_ready),    32'd1);
    chk("rst_out_valid", 32'(out_valid),   32'd0);
    chk("rst_quotient",  quotient,         32'd0);
    chk("rst_remainder", remainder,        32'd0);
    chk("rst_div0",      32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op(32'd100, 32'd7, 1'b0, 1'b0, lat);
    chk("u100_7_lat", 32'(lat), 32'd34);
    chk("u100_7_q", quotient, 32'd14);
    chk("u100_7_r", remainder, 32'd2);
    chk("u100_7_dz", 32'(div_by_zero), 32'd0);
    release_op("u100_7");

    do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, lat);
    chk("sm7_2_lat", 32'(lat), 32'd34);
    chk("sm7_2_q", quotient, 32'hFFFF_FFFD);
    chk("sm7_2_r", remainder, 32'hFFFF_FFFF);
    chk("sm7_2_dz", 32'(div_by_zero), 32'd0);
    release_op("sm7_2");

    do_op(32'h1234_5678, 32'd0, 1'b0, 1'b0, lat);
    chk("div0_lat", 32'(lat), 32'd1);
    chk("div0_q", quotient, 32'hFFFF_FFFF);
    chk("div0_r", remainder, 32'h1234_5678);
    chk("div0_dz", 32'(div_by_zero), 32'd1);
    release_op("div0");

    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, lat);
    chk("ovf_lat", 32'(lat), 32'd1);
    chk("ovf_q", quotient, 32'h8000_0000);
    chk("ovf_r", remainder, 32'd0);
    chk("ovf_dz", 32'(div_by_zero), 32'd0);
    release_op("ovf");

    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, lat);
    chk("u_big_lat", 32'(lat), 32'd34);
    chk("u_big_q", quotient, 32'd0);
    chk("u_big_r", remainder, 32'h8000_0000);
    release_op("u_big");

    do_op(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, lat);
    chk("s7_m2_q", quotient, 32'hFFFF_FFFD);
    chk("s7_m2_r", remainder, 32'd1);
    release_op("s7_m2");

    do_op(32'hFFFF_FFFF, 32'h10, 1'b0, 1'b0, lat);
    chk("u_ff_16_q", quotient, 32'h0FFF_FFFF);
    chk("u_ff_16_r", remainder, 32'hF);
    release_op("u_ff_16");

    // Back-pressure: result must hold while in_valid keeps toggling
    out_ready = 1'b0;
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, lat);
    chk("bp_lat", 32'(lat), 32'd34);
    for (int k = 0; k < 10; k++) begin
      in_valid = ~in_valid;
      dividend = 32'd5;
      divisor  = 32'd5;
      @(posedge clk);
      #1;
      chk("bp_hold_q", quotient, 32'hFFFF_FFFF);
      chk("bp_hold_r", remainder, 32'd0);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_ready", 32'(in_ready), 32'd0);
    end
    release_op("bp");
    seen = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) seen++;
    end
    chk("bp_no_second_op", 32'(seen), 32'd0);

    // Reset abort at CALC counter 15
    @(negedge clk);
    in_valid  = 1'b1;
    dividend  = 32'd1000;
    divisor   = 32'd3;
    is_signed = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_quotient", quotient, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) seen++;
    end
    chk("abort_no_result", 32'(seen), 32'd0);

    do_op(32'd9, 32'd3, 1'b0, 1'b0, lat);
    chk("u9_3_lat", 32'(lat), 32'd34);
    chk("u9_3_q", quotient, 32'd3);
    chk("u9_3_r", remainder, 32'd0);
    release_op("u9_3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
